frv_lsu_outstanding: RTL

FRV_LSU_OUTSTANDING -- requirements
Module: frv_lsu_outstanding

---
 rtl/frv_common.sv | 23 ++
 rtl/frv_lsu_track_fifo.sv | 76 +++++++
 rtl/frv_lsu_outstanding.sv | 109 ++++++++++
 3 files changed

// File: rtl/frv_common.sv
// Shared constants and types for the FRV core: LSU width codes, alignment
// trap causes and the LSU outstanding-transaction tracking entry.
package frv_common;

  localparam logic [1:0] LSU_BYTE = 2'b00;
  localparam logic [1:0] LSU_HALF = 2'b01;
  localparam logic [1:0] LSU_WORD = 2'b10;

  localparam logic [5:0] TRAP_LDALIGN = 6'd4;
  localparam logic [5:0] TRAP_STALIGN = 6'd6;

  typedef struct packed {
    logic       store;
    logic [1:0] off;
    logic [1:0] width;
    logic       sign;
  } track_entry_t;

  function automatic logic lsuMisaligned(input logic [1:0] width, input logic [1:0] off);
    return ((width == LSU_HALF) && off[0]) || ((width == LSU_WORD) && (off != 2'b00));
  endfunction

endpackage

// File: rtl/frv_lsu_track_fifo.sv
// In-order tracking queue for outstanding data-memory transactions, with a
// per-entry killed flag that a flush sets on every entry at once.
module frv_lsu_track_fifo
  import frv_common::*;
#(
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic               g_clk,
  input  logic               g_resetn,
  input  logic               push_i,
  input  track_entry_t       push_data_i,
  input  logic               pop_i,
  input  logic               kill_all_i,
  output logic [CNT_W-1:0]   count_o,
  output logic               empty_o,
  output track_entry_t       head_o,
  output logic               head_killed_o
);

  track_entry_t             entries_q [DEPTH];
  logic [DEPTH-1:0]         killed_q, killed_d;
  logic [PTR_W-1:0]         head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic                     full, doPush, doPop;

  function automatic logic [PTR_W-1:0] ptrNext(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) return '0;
    return p + PTR_W'(1);
  endfunction

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty_o = (count_q == '0);
  assign doPush  = push_i && !full;
  assign doPop   = pop_i && !empty_o;

  always_comb begin
    killed_d = killed_q;
    head_d   = head_q;
    tail_d   = tail_q;
    count_d  = count_q;
    if (kill_all_i) killed_d = '1;
    // A fresh entry is always live, even if a stale killed bit sat in its slot.
    if (doPush) begin
      killed_d[tail_q] = 1'b0;
      tail_d           = ptrNext(tail_q);
    end
    if (doPop) head_d = ptrNext(head_q);
    if (doPush && !doPop)      count_d = count_q + CNT_W'(1);
    else if (doPop && !doPush) count_d = count_q - CNT_W'(1);
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      killed_q <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      killed_q <= killed_d;
      head_q   <= head_d;
      tail_q   <= tail_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge g_clk) begin
    if (doPush) entries_q[tail_q] <= push_data_i;
  end

  assign count_o       = count_q;
  assign head_o        = entries_q[head_q];
  assign head_killed_o = killed_q[head_q];

endmodule

// File: rtl/frv_lsu_outstanding.sv
// LSU front end that issues byte/half/word accesses to the data bus and keeps
// up to DEPTH of them in flight, completing responses strictly in order.
module frv_lsu_outstanding
  import frv_common::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        g_clk,
  input  logic        g_resetn,
  input  logic        flush,
  input  logic        lsu_valid,
  input  logic        lsu_store,
  input  logic [1:0]  lsu_width,
  input  logic        lsu_signed,
  input  logic [31:0] lsu_addr,
  input  logic [31:0] lsu_wdata,
  input  logic        hold_lsu_req,
  output logic        lsu_ready,
  output logic        lsu_a_error,
  output logic        dmem_req,
  output logic        dmem_wen,
  output logic [3:0]  dmem_strb,
  output logic [31:0] dmem_wdata,
  output logic [31:0] dmem_addr,
  input  logic        dmem_gnt,
  input  logic        dmem_recv,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_error,
  output logic        dmem_ack,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_error,
  input  logic        rsp_busy
);

  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [CNT_W-1:0] count;
  logic             empty, headKilled, killHead, push;
  track_entry_t     pushEntry, head;
  logic [31:0]      shifted;

  assign lsu_a_error = lsu_valid && lsuMisaligned(lsu_width, lsu_addr[1:0]);
  // A request seen during flush belongs to the squashed path and never issues.
  assign dmem_req    = g_resetn && lsu_valid && !lsu_a_error && !hold_lsu_req && !flush
                       && (count < CNT_W'(DEPTH));
  assign push        = dmem_req && dmem_gnt;
  assign lsu_ready   = g_resetn && (lsu_a_error || push);
  assign dmem_wen    = lsu_store;
  assign dmem_addr   = {lsu_addr[31:2], 2'b00};

  always_comb begin
    dmem_strb  = 4'b1111;
    dmem_wdata = lsu_wdata;
    case (lsu_width)
      LSU_BYTE: begin
        dmem_strb  = 4'b0001 << lsu_addr[1:0];
        dmem_wdata = {4{lsu_wdata[7:0]}};
      end
      LSU_HALF: begin
        dmem_strb  = 4'b0011 << lsu_addr[1:0];
        dmem_wdata = {2{lsu_wdata[15:0]}};
      end
      default: ;
    endcase
  end

  always_comb begin
    pushEntry       = '0;
    pushEntry.store = lsu_store;
    pushEntry.off   = lsu_addr[1:0];
    pushEntry.width = lsu_width;
    pushEntry.sign  = lsu_signed;
  end

  frv_lsu_track_fifo #(.DEPTH(DEPTH)) u_fifo (
    .g_clk         (g_clk),
    .g_resetn      (g_resetn),
    .push_i        (push),
    .push_data_i   (pushEntry),
    .pop_i         (dmem_ack),
    .kill_all_i    (flush),
    .count_o       (count),
    .empty_o       (empty),
    .head_o        (head),
    .head_killed_o (headKilled)
  );

  // A head killed by an earlier or the current flush is drained silently.
  assign killHead  = headKilled || flush;
  assign rsp_valid = g_resetn && dmem_recv && !empty && !killHead;
  assign dmem_ack  = g_resetn && dmem_recv && !empty && (killHead || !rsp_busy);
  assign rsp_error = dmem_error;
  assign shifted   = dmem_rdata >> {head.off, 3'b000};

  always_comb begin
    rsp_rdata = shifted;
    if (head.store) begin
      rsp_rdata = '0;
    end else begin
      case (head.width)
        LSU_BYTE: rsp_rdata = {{24{head.sign && shifted[7]}}, shifted[7:0]};
        LSU_HALF: rsp_rdata = {{16{head.sign && shifted[15]}}, shifted[15:0]};
        default:  rsp_rdata = dmem_rdata;
      endcase
    end
  end

endmodule
